// File: rtl/hazard_stall_ctrl.sv
// Decode-stage interlock: a three-slot destination scoreboard (EX/MEM/WB) drives stall/bubble,
// squashes wrong-path decode on flush, and drains the pipeline after HALT.
module hazard_stall_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       idValid,
    input  logic       rd1Used,
    input  logic       rd2Used,
    input  logic [2:0] read1Sel,
    input  logic [2:0] read2Sel,
    input  logic       regWrt,
    input  logic [2:0] writeReg,
    input  logic       halt,
    input  logic       flush,
    output logic       stall,
    output logic       bubble,
    output logic       haltDone,
    output logic [1:0] pending,
    output logic       err
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      v_q, v_d;          // bit 0 = EX, 1 = MEM, 2 = WB
    logic [2:0][2:0] dst_q, dst_d;
    logic [1:0]      pending_q, pending_d;
    logic            halt_done_q, halt_done_d;
    logic            err_q, err_d;

    logic            run_s;
    logic            hazard_s;
    logic            stall_s;
    logic            err_set_s;

    function automatic logic slot_match(input logic [2:0] sel,
                                        input logic [2:0] v,
                                        input logic [2:0][2:0] dst);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (v[i] && (dst[i] == sel)) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    // Hazard detection, stall/bubble, scoreboard shift and next-state logic.
    always_comb begin
        run_s     = (state_q == ST_RUN);
        // No bypass or forwarding: a match in any slot, WB included, is a hazard.
        hazard_s  = idValid & ((rd1Used & slot_match(read1Sel, v_q, dst_q)) |
                               (rd2Used & slot_match(read2Sel, v_q, dst_q)));
        stall_s   = (state_q == ST_DRAIN) | (state_q == ST_HALTED) |
                    (run_s & hazard_s & ~flush);
        err_set_s = (flush & ~run_s) | (~idValid & (rd1Used | rd2Used));

        v_d       = {v_q[1:0], idValid & regWrt & ~stall_s & ~flush & run_s};
        dst_d     = {dst_q[1], dst_q[0], writeReg};
        pending_d = popcount3(v_d);
        err_d     = err_q | err_set_s;

        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (idValid && halt && !hazard_s && !flush) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (v_q == 3'b000) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
        halt_done_d = (state_d == ST_HALTED);
    end

    // State, scoreboard and registered status update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            v_q         <= 3'b000;
            dst_q       <= '0;
            pending_q   <= 2'd0;
            halt_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            dst_q       <= dst_d;
            pending_q   <= pending_d;
            halt_done_q <= halt_done_d;
            err_q       <= err_d;
        end
    end

    assign stall    = stall_s;
    assign bubble   = stall_s | flush;
    assign haltDone = halt_done_q;
    assign pending  = pending_q;
    assign err      = err_q | err_set_s;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a table of per-cycle vectors plus hand-written
// halt-drain, reset-mid-drain and error sequences.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       idValid = 1'b0, rd1Used = 1'b0, rd2Used = 1'b0;
    logic [2:0] read1Sel = 3'd0, read2Sel = 3'd0, writeReg = 3'd0;
    logic       regWrt = 1'b0, halt = 1'b0, flush = 1'b0;
    logic       stall, bubble, haltDone, err;
    logic [1:0] pending;

    int checks = 0;
    int failures = 0;

    hazard_stall_ctrl dut (
        .clk(clk), .rst(rst), .idValid(idValid), .rd1Used(rd1Used), .rd2Used(rd2Used),
        .read1Sel(read1Sel), .read2Sel(read2Sel), .regWrt(regWrt), .writeReg(writeReg),
        .halt(halt), .flush(flush), .stall(stall), .bubble(bubble), .haltDone(haltDone),
        .pending(pending), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       idv, r1u, r2u;
        logic [2:0] s1, s2;
        logic       rw;
        logic [2:0] wr;
        logic       hlt, fl;
        logic       e_stall, e_bubble;
        logic [1:0] e_pend;
        logic       e_err;
    } vec_t;

    vec_t tbl [28];

    function automatic vec_t mk(input logic idv, input logic r1u, input logic r2u,
                                input logic [2:0] s1, input logic [2:0] s2,
                                input logic rw, input logic [2:0] wr,
                                input logic hlt, input logic fl,
                                input logic es, input logic eb, input logic [1:0] ep,
                                input logic ee);
        vec_t v;
        v.idv = idv; v.r1u = r1u; v.r2u = r2u; v.s1 = s1; v.s2 = s2;
        v.rw = rw; v.wr = wr; v.hlt = hlt; v.fl = fl;
        v.e_stall = es; v.e_bubble = eb; v.e_pend = ep; v.e_err = ee;
        return v;
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        idValid = v.idv; rd1Used = v.r1u; rd2Used = v.r2u;
        read1Sel = v.s1; read2Sel = v.s2; regWrt = v.rw; writeReg = v.wr;
        halt = v.hlt; flush = v.fl;
    endtask

    task automatic idle();
        drive(mk(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0,
                 1'b0, 1'b0, 2'd0, 1'b0));
    endtask

    // One cycle: inputs change just after the rising edge, outputs sampled on the falling edge.
    task automatic apply(input string nm, input vec_t v);
        @(posedge clk); #1;
        drive(v);
        @(negedge clk);
        check({nm, ".stall"},    {7'd0, stall},    {7'd0, v.e_stall});
        check({nm, ".bubble"},   {7'd0, bubble},   {7'd0, v.e_bubble});
        check({nm, ".pending"},  {6'd0, pending},  {6'd0, v.e_pend});
        check({nm, ".haltDone"}, {7'd0, haltDone}, 8'd0);
        check({nm, ".err"},      {7'd0, err},      {7'd0, v.e_err});
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst = 1'b1;
        idle();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Three writers to r1, r2, r4 then a HALT in decode (stays in RUN for that cycle).
    task automatic issue_then_halt(input string nm);
        apply({nm, ".p1"}, mk(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
        apply({nm, ".p2"}, mk(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0));
        apply({nm, ".p4"}, mk(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0));
        apply({nm, ".h"},  mk(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int zero_cyc;
        int hd_cyc;

        //            idv   r1u   r2u   s1    s2    rw    wr    hlt   fl  | stall bub  pend  err
        // back-to-back RAW on r3
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        tbl[1]  = mk(1'b1, 1'b1, 1'b0, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
        tbl[2]  = tbl[1];
        tbl[3]  = tbl[1];
        tbl[4]  = mk(1'b1, 1'b1, 1'b0, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        // distance 2 via source 2 on r5
        tbl[5]  = mk(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        tbl[6]  = mk(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
        tbl[7]  = mk(1'b1, 1'b0, 1'b1, 3'd0, 3'd5, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
        tbl[8]  = tbl[7];
        tbl[9]  = mk(1'b1, 1'b0, 1'b1, 3'd0, 3'd5, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        // same fields with the use bits clear: no stall
        tbl[10] = tbl[5];
        tbl[11] = tbl[6];
        tbl[12] = mk(1'b1, 1'b0, 1'b0, 3'd5, 3'd5, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
        tbl[13] = mk(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
        // flush over hazard on r2; the flushed writer of r6 must never stall anyone
        tbl[14] = mk(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        tbl[15] = mk(1'b1, 1'b1, 1'b0, 3'd2, 3'd0, 1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
        tbl[16] = mk(1'b1, 1'b1, 1'b1, 3'd2, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
        tbl[17] = tbl[16];
        tbl[18] = mk(1'b1, 1'b1, 1'b1, 3'd2, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        // register 0 hazards like any other
        tbl[19] = mk(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        tbl[20] = mk(1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
        tbl[21] = tbl[20];
        tbl[22] = tbl[20];
        tbl[23] = mk(1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        // flush + halt: halt ignored, writer not loaded, still RUN
        tbl[24] = mk(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
        tbl[25] = mk(1'b1, 1'b1, 1'b0, 3'd7, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        // source use without a valid instruction: sticky err
        tbl[26] = mk(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        tbl[27] = mk(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

        reset_dut();
        @(negedge clk);
        check("rst.stall",    {7'd0, stall},    8'd0);
        check("rst.bubble",   {7'd0, bubble},   8'd0);
        check("rst.haltDone", {7'd0, haltDone}, 8'd0);
        check("rst.pending",  {6'd0, pending},  8'd0);
        check("rst.err",      {7'd0, err},      8'd0);

        for (int i = 0; i < 28; i++) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // Halt drain: DRAIN next cycle, haltDone one cycle after pending hits 0.
        reset_dut();
        issue_then_halt("drain");
        zero_cyc = -1;
        hd_cyc = -1;
        for (int k = 0; k < 12 && hd_cyc < 0; k++) begin
            @(posedge clk); #1;
            drive(mk(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
            @(negedge clk);
            check($sformatf("drain.stall%0d", k), {7'd0, stall}, 8'd1);
            if (k == 0) check("drain.pend0", {6'd0, pending}, 8'd2);
            if (pending == 2'd0 && zero_cyc < 0) zero_cyc = k;
            if (haltDone === 1'b1) hd_cyc = k;
        end
        check("drain.zero_cyc", zero_cyc[7:0], 8'd2);
        check("drain.hd_cyc",   hd_cyc[7:0],   8'd3);

        // Flush while HALTED sets err; err, haltDone and stall all persist.
        @(posedge clk); #1;
        idle();
        flush = 1'b1;
        @(negedge clk);
        check("halted_flush.err",    {7'd0, err},    8'd1);
        check("halted_flush.bubble", {7'd0, bubble}, 8'd1);
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;
        @(negedge clk);
        check("halted.err_sticky", {7'd0, err},      8'd1);
        check("halted.haltDone",   {7'd0, haltDone}, 8'd1);
        check("halted.stall",      {7'd0, stall},    8'd1);

        // Reset while draining with two writers still in flight.
        reset_dut();
        issue_then_halt("mid");
        apply("mid.drain", mk(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0,
                              1'b1, 1'b1, 2'd2, 1'b0));
        @(posedge clk); #1;
        rst = 1'b1;
        idle();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst.pending",  {6'd0, pending},  8'd0);
        check("mid_rst.haltDone", {7'd0, haltDone}, 8'd0);
        check("mid_rst.stall",    {7'd0, stall},    8'd0);
        check("mid_rst.bubble",   {7'd0, bubble},   8'd0);
        check("mid_rst.err",      {7'd0, err},      8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
